// File: rtl/ahb_slave_resp_mux_if.sv
// Bus bundle between the AHB master port, the address decoder and the response mux.
interface ahb_slave_resp_mux_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32
);
    logic [N-1:0]    hreq;
    logic            default_slv_sel;
    logic [1:0]      htrans;
    logic [N*DW-1:0] hrdata_s;
    logic [N-1:0]    hreadyout_s;
    logic [2*N-1:0]  hresp_s;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic [1:0]      hresp;
    logic [N-1:0]    hsel_dp;

    modport slave (
        input  hreq, default_slv_sel, htrans, hrdata_s, hreadyout_s, hresp_s,
        output hrdata, hready, hresp, hsel_dp
    );

    modport master (
        output hreq, default_slv_sel, htrans, hrdata_s, hreadyout_s, hresp_s,
        input  hrdata, hready, hresp, hsel_dp
    );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// AHB response mux with built-in default slave (two-cycle ERROR for unmapped accesses).
// Optional wait-state watchdog enabled by defining AHB_RESP_TIMEOUT_EN.
module ahb_slave_resp_mux #(
    parameter int unsigned MASTER_X_SLAVE_NUM = 4,
    parameter int unsigned AHB_DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    ahb_slave_resp_mux_if.slave  bus
);
    localparam int unsigned N  = MASTER_X_SLAVE_NUM;
    localparam int unsigned DW = AHB_DATA_WIDTH;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_e;

    logic [N-1:0] dp_sel_q, dp_sel_d;
    logic         dp_def_q, dp_def_d;
    def_state_e   def_state_q, def_state_d;

    logic          hready_c;
    logic          accept;
    logic          unmapped_acc;
    logic          slv_path;
    logic          timeout;
    logic [DW-1:0] slv_rdata;
    logic          slv_ready;
    logic [1:0]    slv_resp;

    assign accept       = hready_c;
    assign unmapped_acc = accept & bus.default_slv_sel & bus.htrans[1];
    // An unmapped data phase is answered by the default slave even if hreq overlapped it.
    assign slv_path     = (dp_sel_q != '0) && !dp_def_q;

    // Lowest-index selected slave wins when the decoder map overlaps.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = RESP_OKAY;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (dp_sel_q[i]) begin
                slv_rdata = bus.hrdata_s[i*DW +: DW];
                slv_ready = bus.hreadyout_s[i];
                slv_resp  = bus.hresp_s[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            dp_sel_q    <= '0;
            dp_def_q    <= 1'b0;
            def_state_q <= DEF_IDLE;
        end else begin
            dp_sel_q    <= dp_sel_d;
            dp_def_q    <= dp_def_d;
            def_state_q <= def_state_d;
        end
    end

    always_comb begin
        dp_sel_d    = dp_sel_q;
        dp_def_d    = dp_def_q;
        def_state_d = def_state_q;
        if (accept) begin
            dp_sel_d = bus.hreq;
            dp_def_d = unmapped_acc;
        end
        case (def_state_q)
            DEF_IDLE: if (unmapped_acc) def_state_d = DEF_ERR1;
            DEF_ERR1: def_state_d = DEF_ERR2;
            DEF_ERR2: def_state_d = unmapped_acc ? DEF_ERR1 : DEF_IDLE;
            default:  def_state_d = DEF_IDLE;
        endcase
        // A stuck slave is abandoned and the master gets the default-slave error instead.
        if (timeout) begin
            dp_sel_d    = '0;
            dp_def_d    = 1'b0;
            def_state_d = DEF_ERR1;
        end
    end

    always_comb begin
        hready_c   = 1'b1;
        bus.hresp  = RESP_OKAY;
        bus.hrdata = '0;
        if (slv_path) begin
            hready_c   = slv_ready;
            bus.hresp  = slv_resp;
            bus.hrdata = slv_rdata;
        end else begin
            case (def_state_q)
                DEF_ERR1: begin
                    hready_c  = 1'b0;
                    bus.hresp = RESP_ERROR;
                end
                DEF_ERR2: bus.hresp = RESP_ERROR;
                default:  ;
            endcase
        end
    end

    assign bus.hready  = hready_c;
    assign bus.hsel_dp = dp_sel_q;

`ifdef AHB_RESP_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              slv_waiting;

    assign slv_waiting = slv_path && !slv_ready;
    assign timeout     = slv_waiting && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (hready_c || timeout) begin
            wait_cnt_d = '0;
        end else if (slv_waiting) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Directed + randomized bench for ahb_slave_resp_mux against a transaction-level response model.
`timescale 1ns/1ps
module tb_ahb_slave_resp_mux;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    localparam int K_NONE = 0;
    localparam int K_SLV  = 1;
    localparam int K_ERR  = 2;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;

    ahb_slave_resp_mux_if #(.N(N), .DW(DW)) bus ();

    ahb_slave_resp_mux #(
        .MASTER_X_SLAVE_NUM (N),
        .AHB_DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what kind of data phase is in progress and how far it has got.
    int          m_kind = K_NONE;
    logic [N-1:0] m_sel = '0;
    bit          m_err_second = 1'b0;
    int          m_wait = 0;
    logic        e_hready = 1'b1;
    logic [1:0]  e_hresp = 2'b00;
    logic [31:0] e_hrdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [N-1:0] lowbit;
        int idx;
        e_hready = 1'b1;
        e_hresp  = 2'b00;
        e_hrdata = '0;
        if (m_kind == K_ERR) begin
            e_hresp  = 2'b01;
            e_hready = m_err_second;
        end else if (m_kind == K_SLV) begin
            lowbit   = m_sel & (~m_sel + 4'd1);
            idx      = $clog2(lowbit);
            e_hrdata = bus.hrdata_s[idx*32 +: 32];
            e_hready = bus.hreadyout_s[idx];
            e_hresp  = bus.hresp_s[idx*2 +: 2];
        end
    endtask

    // Advance the model across one rising edge using the inputs held at that edge.
    task automatic model_edge();
        if (!hreset_n) begin
            m_kind = K_NONE;
            m_sel  = '0;
            m_err_second = 1'b0;
            m_wait = 0;
            return;
        end
`ifdef AHB_RESP_TIMEOUT_EN
        if (m_kind == K_SLV && !e_hready) begin
            if (m_wait == int'(TO)) begin
                m_kind = K_ERR;
                m_err_second = 1'b0;
                m_sel  = '0;
                m_wait = 0;
                return;
            end
            m_wait++;
        end else if (e_hready) begin
            m_wait = 0;
        end
`endif
        if (e_hready) begin
            m_sel = bus.hreq;
            m_err_second = 1'b0;
            if (bus.default_slv_sel && bus.htrans[1]) m_kind = K_ERR;
            else if (bus.hreq != '0)                  m_kind = K_SLV;
            else                                      m_kind = K_NONE;
        end else if (m_kind == K_ERR) begin
            m_err_second = 1'b1;
        end
    endtask

    task automatic settle_check();
        #1;
        model_eval();
        chk("hready",  32'(bus.hready),  32'(e_hready));
        chk("hresp",   32'(bus.hresp),   32'(e_hresp));
        chk("hrdata",  bus.hrdata,       e_hrdata);
        chk("hsel_dp", 32'(bus.hsel_dp), 32'(m_sel));
    endtask

    task automatic tick();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.hreq = '0;
        bus.default_slv_sel = 1'b0;
        bus.htrans = 2'b00;
        bus.hreadyout_s = '1;
        bus.hresp_s = '0;
        bus.hrdata_s = '0;
    endtask

    initial begin
        idle_inputs();

        // Reset for two cycles
        hreset_n = 1'b0;
        tick(); tick();
        settle_check();
        chk("rst_hready", 32'(bus.hready), 32'd1);
        chk("rst_hresp",  32'(bus.hresp),  32'd0);
        chk("rst_hrdata", bus.hrdata,      32'd0);
        chk("rst_hsel",   32'(bus.hsel_dp), 32'd0);
        hreset_n = 1'b1;

        // Read slave1 with one wait state
        bus.hreq = 4'b0010; bus.htrans = 2'b10;
        settle_check(); tick();
        bus.hreq = '0; bus.htrans = 2'b00; bus.hreadyout_s[1] = 1'b0;
        settle_check();
        chk("rd1_wait", 32'(bus.hready), 32'd0);
        tick();
        bus.hreadyout_s[1] = 1'b1; bus.hrdata_s[32 +: 32] = 32'hDEADBEEF;
        settle_check();
        chk("rd1_ready", 32'(bus.hready), 32'd1);
        chk("rd1_data",  bus.hrdata,      32'hDEADBEEF);
        chk("rd1_resp",  32'(bus.hresp),  32'd0);
        tick();

        // Unmapped NONSEQ -> two-cycle ERROR
        idle_inputs();
        bus.default_slv_sel = 1'b1; bus.htrans = 2'b10;
        settle_check(); tick();
        bus.default_slv_sel = 1'b0; bus.htrans = 2'b00;
        settle_check();
        chk("err1", {bus.hready, bus.hresp}, 32'b0_01);
        tick();
        settle_check();
        chk("err2", {bus.hready, bus.hresp}, 32'b1_01);
        tick();
        settle_check();
        chk("err_done", {bus.hready, bus.hresp}, 32'b1_00);

        // Unmapped BUSY: zero-wait OKAY
        bus.default_slv_sel = 1'b1; bus.htrans = 2'b01;
        settle_check(); tick();
        bus.default_slv_sel = 1'b0; bus.htrans = 2'b00;
        settle_check();
        chk("busy_unmapped", {bus.hready, bus.hresp}, 32'b1_00);

        // Pipelined slave0 then slave2, slave0 stalls two cycles
        bus.hreq = 4'b0001; bus.htrans = 2'b10;
        settle_check(); tick();
        bus.hreq = 4'b0100; bus.htrans = 2'b11; bus.hreadyout_s[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.hreadyout_s[0] = 1'b1;
            settle_check();
            chk("pipe_hold", 32'(bus.hsel_dp), 32'b0001);
            tick();
        end
        bus.hreq = '0; bus.htrans = 2'b00;
        settle_check();
        chk("pipe_next", 32'(bus.hsel_dp), 32'b0100);
        tick();

        // Reset while in DEF_ERR1
        bus.default_slv_sel = 1'b1; bus.htrans = 2'b10;
        settle_check(); tick();
        bus.default_slv_sel = 1'b0; bus.htrans = 2'b00;
        settle_check();
        hreset_n = 1'b0;
        tick();
        hreset_n = 1'b1;
        settle_check();
        chk("rst_err1", {bus.hready, bus.hresp}, 32'b1_00);

        // Slave3 stuck low for 20 cycles
        bus.hreq = 4'b1000; bus.htrans = 2'b10;
        settle_check(); tick();
        bus.hreq = '0; bus.htrans = 2'b00; bus.hreadyout_s[3] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            settle_check();
`ifndef AHB_RESP_TIMEOUT_EN
            chk("stall_forever", 32'(bus.hready), 32'd0);
`endif
            tick();
        end
        bus.hreadyout_s[3] = 1'b1;
        hreset_n = 1'b0;
        tick();
        hreset_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0:       bus.hreq = '0;
                1, 2, 3: bus.hreq = 4'(1 << $urandom_range(0, 3));
                default: bus.hreq = 4'($urandom);
            endcase
            bus.htrans = 2'($urandom);
            bus.default_slv_sel = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < int'(N); i++) begin
                bus.hreadyout_s[i] = ($urandom_range(0, 3) != 0);
                bus.hresp_s[i*2 +: 2] = {1'b0, 1'($urandom)};
                bus.hrdata_s[i*32 +: 32] = $urandom;
            end
            hreset_n = ($urandom_range(0, 39) != 0);
            settle_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
